// File: rtl/sram_req_arbiter.sv
// Arbitrates the fetch and data requesters onto one req/addr_ok/data_ok memory port,
// remembering the issue order so each in-order response goes back to its originator.
module sram_req_arbiter #(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        proto_err
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  logic [CW-1:0]      r_count;
  logic [PW-1:0]      r_wrPtr;
  logic [PW-1:0]      r_rdPtr;
  logic [MAX_OUT-1:0] r_idFifo;
  logic [SW-1:0]      r_starveCnt;
  logic               r_protoErr;

  logic w_full;
  logic w_empty;
  logic w_starved;
  logic w_grantInst;
  logic w_grantData;
  logic w_accept;
  logic w_pop;
  logic w_headId;

  assign w_full    = (r_count == CW'(MAX_OUT));
  assign w_empty   = (r_count == '0);
  assign w_starved = (r_starveCnt == SW'(STARVE_LIM));
  assign w_accept  = (w_grantInst | w_grantData) & m_addr_ok;
  assign w_pop     = m_data_ok & ~w_empty;
  assign w_headId  = r_idFifo[r_rdPtr];

  // Data normally wins; fetch is forced through once it has lost STARVE_LIM times in a row.
  always_comb begin
    w_grantInst = 1'b0;
    w_grantData = 1'b0;
    if (!w_full) begin
      if (data_req && inst_req && w_starved) w_grantInst = 1'b1;
      else if (data_req)                     w_grantData = 1'b1;
      else if (inst_req)                     w_grantInst = 1'b1;
    end
  end

  always_comb begin
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = 2'd0;
    m_wstrb      = 4'd0;
    m_addr       = 32'd0;
    m_wdata      = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_rdata   = 32'd0;
    proto_err    = 1'b0;
    if (resetn) begin
      m_req = w_grantInst | w_grantData;
      if (w_grantData) begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_wstrb = data_wr ? data_wstrb : 4'd0;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else if (w_grantInst) begin
        m_size  = 2'd2;
        m_addr  = inst_addr;
      end
      inst_addr_ok = w_grantInst & m_addr_ok;
      data_addr_ok = w_grantData & m_addr_ok;
      inst_data_ok = w_pop & ~w_headId;
      data_data_ok = w_pop & w_headId;
      inst_rdata   = m_rdata;
      data_rdata   = m_rdata;
      proto_err    = r_protoErr;
    end
  end

  // ID FIFO holds 0 for fetch, 1 for data, in the order requests were accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count     <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_idFifo    <= '0;
      r_starveCnt <= '0;
      r_protoErr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idFifo[r_wrPtr] <= w_grantData;
        r_wrPtr           <= r_wrPtr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + CW'(w_accept) - CW'(w_pop);
      if (m_data_ok && w_empty) r_protoErr <= 1'b1;
      if (!inst_req || (w_accept && w_grantInst))
        r_starveCnt <= '0;
      else if (w_accept && w_grantData && !w_starved)
        r_starveCnt <= r_starveCnt + 1'b1;
    end
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stage).
- The unified port uses a variable-latency req/addr_ok/data_ok handshake, so the five-stage pipeline can later sit behind a single bridge.
- Tracks outstanding transactions in issue order and routes each in-order response back to its originator.
- Fixed data-over-instruction priority, with an anti-starvation guard for fetch.

Parameters:
- MAX_OUT, 4: maximum outstanding transactions on the unified port (power of two, 2..8).
- STARVE_LIM, 3: consecutive data grants while fetch is waiting before fetch is forced to win.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address (always read, size 2)
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response (read data or write ack) this cycle
- data_rdata  out  32  data read data
- m_req  out  1  unified request
- m_wr  out  1  unified write
- m_size  out  2  unified size
- m_wstrb  out  4  unified strobes (0000 for reads)
- m_addr  out  32  unified address
- m_wdata  out  32  unified write data
- m_addr_ok  in  1  downstream accepted request
- m_data_ok  in  1  downstream response valid, strictly in issue order
- m_rdata  in  32  downstream read data
- proto_err  out  1  sticky: m_data_ok received with nothing outstanding

Behaviour:
- Reset (resetn=0, async) clears:
  - outstanding count to 0
  - ID FIFO pointers to 0
  - starvation counter to 0
  - proto_err to 0
- While in reset, all outputs are 0.
- full = (count == MAX_OUT).
- Grant (combinational):
  - If full, no grant; m_req=0.
  - Else if data_req and inst_req and starve_cnt == STARVE_LIM, grant fetch.
  - Else if data_req, grant data.
  - Else if inst_req, grant fetch.
  - Otherwise no grant.
- m_* fields are muxed from the granted requester. Fetch drives m_wr=0, m_size=2, m_wstrb=0, m_wdata=0.
- For reads, m_wstrb=0 regardless of data_wstrb.
- When no grant, m_req=0 and the other m_* fields are don't-care; the bench checks only m_req.
- Acceptance:
  - inst_addr_ok = grant_inst & m_addr_ok; data_addr_ok = grant_data & m_addr_ok.
  - The non-granted requester sees addr_ok=0 and must hold its request.
- On an accepted request, the requester ID (0 = inst, 1 = data) is pushed into the ID FIFO (depth MAX_OUT).
- Response routing:
  - On m_data_ok with the FIFO non-empty, pop the head ID.
  - Assert inst_data_ok or data_data_ok in the same cycle (combinational from m_data_ok).
  - inst_rdata = data_rdata = m_rdata, passed through unmasked.
- Count update:
  - count += accept, count -= (m_data_ok & non-empty).
  - Accept and return in the same cycle leave count unchanged; both the push and the pop occur.
  - A return in the cycle count == MAX_OUT does not unblock a grant until the next cycle (full is evaluated on the registered count).
- m_data_ok with an empty FIFO: ignored (no data_ok to either requester, count stays 0), and proto_err is set to 1 until reset.
- Starvation counter:
  - Increments (saturating at STARVE_LIM) on each accepted data request while inst_req=1.
  - Clears on an accepted fetch or whenever inst_req=0.
- Pointers wrap modulo MAX_OUT.
- Reset mid-transaction discards all outstanding IDs; any later m_data_ok for them raises proto_err.
- Latency: zero added cycles in both request and response paths.

Test Plan:
- Single fetch: inst_req=1, addr 0xBFC00000, m_addr_ok=1; two cycles later m_data_ok=1, m_rdata=0x3C010001 -> m_addr=0xBFC00000, m_wr=0, inst_addr_ok=1 for one cycle, then inst_data_ok=1 with rdata 0x3C010001, data_data_ok=0.
- Conflict: inst_req and data_req both 1, data_wr=1, addr 0x1000, wstrb 1111, m_addr_ok=1 for one cycle -> data granted, m_wstrb=1111, inst_addr_ok=0; next cycle fetch is granted.
- Starvation: data_req held 1 with back-to-back accepts while inst_req=1, STARVE_LIM=3 -> accepted sequence is D, D, D, I, D, ...; counter returns to 0 after the I.
- Full: m_data_ok held 0, fetch streaming with m_addr_ok=1 -> exactly 4 accepts, then m_req=0. One m_data_ok -> response goes to inst, m_req reasserts the next cycle.
- Ordering: issue I, D, I; return three m_data_ok with rdata 0xA, 0xB, 0xC -> inst_data_ok(0xA), data_data_ok(0xB), inst_data_ok(0xC); same-cycle accept and return keep count correct.
- Error/reset: m_data_ok=1 with nothing outstanding -> proto_err=1 and held. Assert resetn=0 mid-burst -> all outputs 0 immediately; after release, count 0 and proto_err 0.
